// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: byte/half/word loads and stores against a
// word-organised array, with a fixed request-to-response latency and error reporting.
module dmem_responder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_write_i,
  input  logic [DATA_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  input  logic [1:0]            req_type_i,
  input  logic                  req_sign_i,
  output logic                  resp_valid_o,
  input  logic                  resp_ready_i,
  output logic [DATA_WIDTH-1:0] resp_rdata_o,
  output logic                  resp_err_o
);

  localparam int unsigned IdxW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [DATA_WIDTH:0] ByteLimit = (DATA_WIDTH + 1)'(64'(DEPTH_WORDS) * 64'd4);

  typedef enum logic [1:0] {StIdle, StWait, StResp} stateT;

  stateT                 stateQ, stateD;
  logic [3:0]            cntQ, cntD;
  logic [DATA_WIDTH-1:0] rdataQ;
  logic                  errQ;

  logic [31:0]           mem [DEPTH_WORDS];
  logic [IdxW-1:0]       wordIdx;
  logic [1:0]            byteLane;
  logic [31:0]           rdWord;
  logic [7:0]            laneByte;
  logic [15:0]           laneHalf;
  logic                  reqErr;
  logic                  accept;
  logic [DATA_WIDTH-1:0] loadData;
  logic [31:0]           wrData;
  logic [3:0]            byteEn;

  // Ready is masked by the asynchronous reset so it reads 0 the whole time rst is low.
  assign req_ready_o  = (stateQ == StIdle) & rst;
  assign resp_valid_o = (stateQ == StResp);
  assign resp_rdata_o = rdataQ;
  assign resp_err_o   = errQ;
  assign accept       = req_valid_i & req_ready_o;

  assign byteLane = req_addr_i[1:0];
  assign wordIdx  = req_addr_i[2 +: IdxW];
  assign rdWord   = mem[wordIdx];
  assign laneByte = rdWord[{byteLane, 3'b000} +: 8];
  assign laneHalf = rdWord[{req_addr_i[1], 4'b0000} +: 16];

  always_comb begin
    reqErr = 1'b0;
    case (req_type_i)
      2'b00:   reqErr = 1'b0;
      2'b01:   reqErr = req_addr_i[0];
      2'b10:   reqErr = |req_addr_i[1:0];
      default: reqErr = 1'b1;
    endcase
    if ({1'b0, req_addr_i} >= ByteLimit) reqErr = 1'b1;
  end

  always_comb begin
    loadData = '0;
    case (req_type_i)
      2'b00:   loadData = req_sign_i ? DATA_WIDTH'($signed(laneByte)) : DATA_WIDTH'(laneByte);
      2'b01:   loadData = req_sign_i ? DATA_WIDTH'($signed(laneHalf)) : DATA_WIDTH'(laneHalf);
      default: loadData = DATA_WIDTH'(rdWord);
    endcase
    if (req_write_i || reqErr) loadData = '0;
  end

  // Store data is right-aligned; replicate it across the word and let byteEn pick lanes.
  always_comb begin
    wrData = req_wdata_i[31:0];
    byteEn = 4'b1111;
    case (req_type_i)
      2'b00: begin
        wrData = {4{req_wdata_i[7:0]}};
        byteEn = 4'b0001 << byteLane;
      end
      2'b01: begin
        wrData = {2{req_wdata_i[15:0]}};
        byteEn = req_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        wrData = req_wdata_i[31:0];
        byteEn = 4'b1111;
      end
    endcase
  end

  // Storage is deliberately outside the reset domain so its contents survive reset.
  always_ff @(posedge clk) begin
    if (accept && req_write_i && !reqErr) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[wordIdx][8*b +: 8] <= wrData[8*b +: 8];
      end
    end
  end

  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      StIdle: begin
        if (accept) begin
          if (LATENCY > 1) begin
            stateD = StWait;
            cntD   = 4'(LATENCY - 2);
          end else begin
            stateD = StResp;
          end
        end
      end
      StWait: begin
        if (cntQ == 4'd0) stateD = StResp;
        else              cntD   = cntQ - 4'd1;
      end
      StResp: begin
        if (resp_ready_i) stateD = StIdle;
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ <= StIdle;
      cntQ   <= 4'd0;
      rdataQ <= '0;
      errQ   <= 1'b0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
      if (accept) begin
        rdataQ <= loadData;
        errQ   <= reqErr;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of single transactions plus
// hand-written stall and reset-during-wait sequences.
module tb_dmem_responder;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned LAT   = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          reqValid = 1'b0;
  logic          reqReady;
  logic          reqWrite = 1'b0;
  logic [DW-1:0] reqAddr = '0;
  logic [DW-1:0] reqWdata = '0;
  logic [1:0]    reqType = 2'b00;
  logic          reqSign = 1'b0;
  logic          respValid;
  logic          respReady = 1'b0;
  logic [DW-1:0] respRdata;
  logic          respErr;

  always #5 clk = ~clk;

  dmem_responder #(
    .DATA_WIDTH (DW),
    .DEPTH_WORDS(DEPTH),
    .LATENCY    (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (reqValid),
    .req_ready_o (reqReady),
    .req_write_i (reqWrite),
    .req_addr_i  (reqAddr),
    .req_wdata_i (reqWdata),
    .req_type_i  (reqType),
    .req_sign_i  (reqSign),
    .resp_valid_o(respValid),
    .resp_ready_i(respReady),
    .resp_rdata_o(respRdata),
    .resp_err_o  (respErr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  typ;
    logic        sgn;
    logic [31:0] expData;
    logic        expErr;
  } vecT;

  vecT vecs[$];
  int  nChecks = 0;
  int  nErrors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void addVec(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [1:0] typ, input logic sgn,
                                 input logic [31:0] expData, input logic expErr);
    vecT v;
    v.wr = wr; v.addr = addr; v.wdata = wdata; v.typ = typ; v.sgn = sgn;
    v.expData = expData; v.expErr = expErr;
    vecs.push_back(v);
  endfunction

  // Drives one request at #1 after an edge, counts edges to the response, then consumes it.
  task automatic doTxn(input vecT v, input string tag, output logic [31:0] rdata, output logic err);
    int waitCnt;
    int lat;
    reqValid = 1'b1;
    reqWrite = v.wr;
    reqAddr  = v.addr;
    reqWdata = v.wdata;
    reqType  = v.typ;
    reqSign  = v.sgn;
    waitCnt  = 0;
    while (!reqReady && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    if (!reqReady) begin
      check({tag, " accept timeout"}, 32'(reqReady), 32'd1);
      reqValid = 1'b0;
      rdata    = '0;
      err      = 1'b0;
      return;
    end
    @(posedge clk); #1;
    // Scramble request inputs after accept; the response must not depend on them.
    reqValid = 1'b0;
    reqWrite = ~v.wr;
    reqAddr  = 32'hFFFF_FFFF;
    reqWdata = $urandom;
    reqType  = 2'b11;
    reqSign  = ~v.sgn;
    lat = 1;
    while (!respValid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'(LAT));
    rdata = respRdata;
    err   = respErr;
    respReady = 1'b1;
    @(posedge clk); #1;
    respReady = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    logic [31:0] held;
    vecT         v;
    int          waitCnt;

    addVec(1, 32'h10,   32'hDEADBEEF, 2'b10, 0, 32'h0,        0);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'hDEADBEEF, 0);
    addVec(0, 32'h13,   32'h0,        2'b00, 1, 32'hFFFFFFDE, 0);
    addVec(0, 32'h13,   32'h0,        2'b00, 0, 32'h000000DE, 0);
    addVec(0, 32'h10,   32'h0,        2'b01, 1, 32'hFFFFBEEF, 0);
    addVec(0, 32'h12,   32'h0,        2'b01, 0, 32'h0000DEAD, 0);
    addVec(1, 32'h11,   32'hAAAAAA55, 2'b00, 0, 32'h0,        0);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'hDEAD55EF, 0);
    addVec(0, 32'h10,   32'h0,        2'b10, 1, 32'hDEAD55EF, 0);
    addVec(0, 32'h10,   32'h0,        2'b00, 1, 32'hFFFFFFEF, 0);
    addVec(0, 32'h11,   32'h0,        2'b00, 1, 32'h00000055, 0);
    addVec(1, 32'h20,   32'h12345678, 2'b10, 0, 32'h0,        0);
    addVec(1, 32'h21,   32'h0000FFFF, 2'b01, 0, 32'h0,        1);
    addVec(0, 32'h20,   32'h0,        2'b10, 0, 32'h12345678, 0);
    addVec(1, 32'h22,   32'h1111CAFE, 2'b01, 1, 32'h0,        0);
    addVec(0, 32'h20,   32'h0,        2'b10, 0, 32'hCAFE5678, 0);
    addVec(0, 32'h22,   32'h0,        2'b01, 1, 32'hFFFFCAFE, 0);
    addVec(0, 32'h12,   32'h0,        2'b10, 0, 32'h0,        1);
    addVec(0, 32'h1000, 32'h0,        2'b10, 0, 32'h0,        1);
    addVec(1, 32'h0,    32'h01020304, 2'b10, 0, 32'h0,        0);
    addVec(1, 32'h1000, 32'hFFFFFFFF, 2'b10, 0, 32'h0,        1);
    addVec(0, 32'h0,    32'h0,        2'b10, 0, 32'h01020304, 0);
    addVec(1, 32'h10,   32'h0,        2'b11, 0, 32'h0,        1);
    addVec(0, 32'h10,   32'h0,        2'b11, 0, 32'h0,        1);
    addVec(0, 32'h10,   32'h0,        2'b10, 0, 32'hDEAD55EF, 0);
    addVec(1, 32'hFFC,  32'hA5A5A5A5, 2'b10, 0, 32'h0,        0);
    addVec(0, 32'hFFC,  32'h0,        2'b10, 0, 32'hA5A5A5A5, 0);
    addVec(0, 32'hFFF,  32'h0,        2'b00, 1, 32'hFFFFFFA5, 0);
    addVec(0, 32'h1003, 32'h0,        2'b00, 0, 32'h0,        1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset ready", 32'(reqReady), 32'd0);
    check("reset valid", 32'(respValid), 32'd0);
    check("reset rdata", respRdata, 32'h0);
    check("reset err", 32'(respErr), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("ready after reset", 32'(reqReady), 32'd1);

    foreach (vecs[i]) begin
      doTxn(vecs[i], $sformatf("vec%0d", i), rd, er);
      check($sformatf("vec%0d rdata", i), rd, vecs[i].expData);
      check($sformatf("vec%0d err", i), 32'(er), 32'(vecs[i].expErr));
    end

    // Response stall: outputs hold while resp_ready is low, and a pending store is ignored.
    reqValid = 1'b1; reqWrite = 1'b0; reqAddr = 32'hFFC; reqType = 2'b10; reqSign = 1'b0;
    check("stall idle ready", 32'(reqReady), 32'd1);
    @(posedge clk); #1;
    reqWrite = 1'b1; reqWdata = 32'h0; reqAddr = 32'hFFC;
    waitCnt = 0;
    while (!respValid && waitCnt < 20) begin
      @(posedge clk); #1;
      waitCnt++;
    end
    check("stall resp arrives", 32'(respValid), 32'd1);
    held = respRdata;
    check("stall rdata", held, 32'hA5A5A5A5);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall%0d valid", c), 32'(respValid), 32'd1);
      check($sformatf("stall%0d rdata", c), respRdata, 32'hA5A5A5A5);
      check($sformatf("stall%0d ready", c), 32'(reqReady), 32'd0);
    end
    respReady = 1'b1;
    check("consume cycle ready", 32'(reqReady), 32'd0);
    @(posedge clk); #1;
    respReady = 1'b0;
    reqValid  = 1'b0;
    check("after consume valid", 32'(respValid), 32'd0);
    check("after consume ready", 32'(reqReady), 32'd1);
    v.wr = 0; v.addr = 32'hFFC; v.wdata = 0; v.typ = 2'b10; v.sgn = 0; v.expData = 0; v.expErr = 0;
    doTxn(v, "post-stall", rd, er);
    check("post-stall rdata", rd, 32'hA5A5A5A5);

    // Reset while a store waits for its response.
    reqValid = 1'b1; reqWrite = 1'b1; reqAddr = 32'h30; reqWdata = 32'h0BADF00D;
    reqType = 2'b10; reqSign = 1'b0;
    @(posedge clk); #1;
    reqValid = 1'b0;
    check("rwait valid", 32'(respValid), 32'd0);
    #2 rst = 1'b0;
    #1;
    check("rwait reset valid", 32'(respValid), 32'd0);
    check("rwait reset ready", 32'(reqReady), 32'd0);
    check("rwait reset err", 32'(respErr), 32'd0);
    @(posedge clk); #1;
    check("rwait held valid", 32'(respValid), 32'd0);
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    check("rwait release ready", 32'(reqReady), 32'd1);
    v.addr = 32'h30;
    doTxn(v, "rwait load", rd, er);
    check("rwait load rdata", rd, 32'h0BADF00D);
    check("rwait load err", 32'(er), 32'd0);
    v.addr = 32'h10;
    doTxn(v, "kept load", rd, er);
    check("kept load rdata", rd, 32'hDEAD55EF);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
